// File: rtl/temperature_scanner.sv
// temperature_scanner: multi-channel sequential temperature calculator.
// Snapshots a base/reference pair and CHANNELS ADC samples on start. Each
// channel then goes through a restoring divider, so that
// tempc = tc_base + adc/tc_ref and drd = adc % tc_ref. The results are
// streamed out with a valid strobe, and a per-scan maximum is tracked.
// All outputs are registered, so each one trails the FSM state that
// produces it by one cycle.
module temperature_scanner #(
    parameter int CHANNELS = 4,
    parameter int ADC_W    = 16,
    parameter int REF_W    = 8,
    parameter int OUT_W    = 32,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [OUT_W-1:0]          tc_base,
    input  logic [REF_W-1:0]          tc_ref,
    input  logic [ADC_W*CHANNELS-1:0] adc_data,
    output logic                      busy,
    output logic                      res_valid,
    output logic [CH_W-1:0]           res_ch,
    output logic [OUT_W-1:0]          tempc,
    output logic [OUT_W-1:0]          drd,
    output logic                      div_err,
    output logic                      done,
    output logic [OUT_W-1:0]          scan_max,
    output logic [CH_W-1:0]           scan_max_ch
);

    localparam int CNT_W = (ADC_W > 1) ? $clog2(ADC_W) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DIV  = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t             state_r, state_s;

    // Scan snapshot
    logic [OUT_W-1:0]   tc_base_r;
    logic [REF_W-1:0]   tc_ref_r;
    logic [ADC_W-1:0]   adc_snap_r [CHANNELS];
    logic [CH_W-1:0]    ch_r;

    // Divider: dvd_r shifts the dividend out and the quotient in
    logic [ADC_W-1:0]   dvd_r;
    logic [REF_W-1:0]   rem_r;
    logic [CNT_W-1:0]   bit_cnt_r;
    logic               err_r;

    // Running maximum of the scan in progress
    logic [OUT_W-1:0]   run_max_r;
    logic [CH_W-1:0]    run_max_ch_r;

    // Registered outputs
    logic               busy_r, res_valid_r, div_err_r, done_r;
    logic [CH_W-1:0]    res_ch_r, scan_max_ch_r;
    logic [OUT_W-1:0]   tempc_r, drd_r, scan_max_r;

    // Combinational helpers
    logic [ADC_W-1:0]   adc_cur_s;
    logic [REF_W:0]     rem_sh_s, ref_ext_s;
    logic [REF_W-1:0]   rem_step_s;
    logic               sub_ok_s;
    logic [OUT_W-1:0]   tempc_s, drd_s;
    logic               last_ch_s;

    assign adc_cur_s = adc_snap_r[ch_r];
    assign ref_ext_s = {1'b0, tc_ref_r};
    assign last_ch_s = (ch_r == CH_W'(CHANNELS - 1));

    // One restoring-division step, plus the result values presented in EMIT
    always_comb begin
        rem_sh_s = {rem_r, dvd_r[ADC_W-1]};
        if (rem_sh_s >= ref_ext_s) begin
            sub_ok_s   = 1'b1;
            rem_step_s = REF_W'(rem_sh_s - ref_ext_s);
        end else begin
            sub_ok_s   = 1'b0;
            rem_step_s = REF_W'(rem_sh_s);
        end
        tempc_s = tc_base_r + OUT_W'(dvd_r);
        if (err_r) begin
            drd_s = OUT_W'(adc_cur_s);
        end else begin
            drd_s = OUT_W'(rem_r);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_LOAD;
                else       state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (tc_ref_r == {REF_W{1'b0}}) state_s = ST_EMIT;
                else                           state_s = ST_DIV;
            end
            ST_DIV: begin
                if (bit_cnt_r == {CNT_W{1'b0}}) state_s = ST_EMIT;
                else                            state_s = ST_DIV;
            end
            ST_EMIT: begin
                if (last_ch_s) state_s = ST_DONE;
                else           state_s = ST_LOAD;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Snapshot, divider datapath, running maximum and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc_base_r     <= {OUT_W{1'b0}};
            tc_ref_r      <= {REF_W{1'b0}};
            for (int i = 0; i < CHANNELS; i++) adc_snap_r[i] <= {ADC_W{1'b0}};
            ch_r          <= {CH_W{1'b0}};
            dvd_r         <= {ADC_W{1'b0}};
            rem_r         <= {REF_W{1'b0}};
            bit_cnt_r     <= {CNT_W{1'b0}};
            err_r         <= 1'b0;
            run_max_r     <= {OUT_W{1'b0}};
            run_max_ch_r  <= {CH_W{1'b0}};
            busy_r        <= 1'b0;
            res_valid_r   <= 1'b0;
            done_r        <= 1'b0;
            div_err_r     <= 1'b0;
            res_ch_r      <= {CH_W{1'b0}};
            tempc_r       <= {OUT_W{1'b0}};
            drd_r         <= {OUT_W{1'b0}};
            scan_max_r    <= {OUT_W{1'b0}};
            scan_max_ch_r <= {CH_W{1'b0}};
        end else begin
            busy_r      <= (state_r != ST_IDLE);
            res_valid_r <= (state_r == ST_EMIT);
            done_r      <= (state_r == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        tc_base_r <= tc_base;
                        tc_ref_r  <= tc_ref;
                        for (int i = 0; i < CHANNELS; i++) begin
                            adc_snap_r[i] <= adc_data[i*ADC_W +: ADC_W];
                        end
                        ch_r <= {CH_W{1'b0}};
                    end
                end
                ST_LOAD: begin
                    rem_r     <= {REF_W{1'b0}};
                    bit_cnt_r <= CNT_W'(ADC_W - 1);
                    if (tc_ref_r == {REF_W{1'b0}}) begin
                        dvd_r <= {ADC_W{1'b1}};
                        err_r <= 1'b1;
                    end else begin
                        dvd_r <= adc_cur_s;
                        err_r <= 1'b0;
                    end
                end
                ST_DIV: begin
                    dvd_r     <= {dvd_r[ADC_W-2:0], sub_ok_s};
                    rem_r     <= rem_step_s;
                    bit_cnt_r <= bit_cnt_r - CNT_W'(1);
                end
                ST_EMIT: begin
                    res_ch_r  <= ch_r;
                    tempc_r   <= tempc_s;
                    drd_r     <= drd_s;
                    div_err_r <= err_r;
                    if (!err_r && (tempc_s > run_max_r)) begin
                        run_max_r    <= tempc_s;
                        run_max_ch_r <= ch_r;
                    end
                    if (!last_ch_s) begin
                        ch_r <= ch_r + CH_W'(1);
                    end
                end
                ST_DONE: begin
                    scan_max_r    <= run_max_r;
                    scan_max_ch_r <= run_max_ch_r;
                    run_max_r     <= {OUT_W{1'b0}};
                    run_max_ch_r  <= {CH_W{1'b0}};
                end
                default: begin
                    ch_r <= {CH_W{1'b0}};
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign res_valid   = res_valid_r;
    assign res_ch      = res_ch_r;
    assign tempc       = tempc_r;
    assign drd         = drd_r;
    assign div_err     = div_err_r;
    assign done        = done_r;
    assign scan_max    = scan_max_r;
    assign scan_max_ch = scan_max_ch_r;

endmodule

// File: tb/tb_temperature_scanner.sv
// Directed testbench for temperature_scanner with the default parameters.
module tb_temperature_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] tc_base;
    logic [7:0]  tc_ref;
    logic [63:0] adc_data;
    logic        busy, res_valid, div_err, done;
    logic [1:0]  res_ch, scan_max_ch;
    logic [31:0] tempc, drd, scan_max;

    temperature_scanner dut (
        .clk(clk), .rst(rst), .start(start), .tc_base(tc_base), .tc_ref(tc_ref),
        .adc_data(adc_data), .busy(busy), .res_valid(res_valid), .res_ch(res_ch),
        .tempc(tempc), .drd(drd), .div_err(div_err), .done(done),
        .scan_max(scan_max), .scan_max_ch(scan_max_ch)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int          n_res, done_cyc, done_cnt, first_valid;
    logic [1:0]  r_ch    [16];
    logic [31:0] r_tempc [16];
    logic [31:0] r_drd   [16];
    logic        r_err   [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start a scan and watch it until done, a reset injection, or a 200-cycle bound.
    // Cycle 0 is the start edge; pa/pb pulse start, chg rewrites inputs, rstc asserts rst.
    task automatic run_scan(input int pa, input int pb, input int chg, input int rstc);
        int  c;
        bit  fin;
        n_res = 0; done_cyc = -1; done_cnt = 0; first_valid = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        fin = 1'b0;
        for (int k = 0; k < 200 && !fin; k++) begin
            @(posedge clk); #1;
            c++;
            if (res_valid) begin
                if (first_valid < 0) first_valid = c;
                if (n_res < 16) begin
                    r_ch[n_res] = res_ch; r_tempc[n_res] = tempc;
                    r_drd[n_res] = drd;   r_err[n_res] = div_err;
                end
                n_res++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
                fin = 1'b1;
            end
            start = (c == pa) || (c == pb);
            if (c == chg) begin
                tc_base  = 32'd1000;
                tc_ref   = 8'd3;
                adc_data = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
            end
            if (c == rstc) begin
                rst = 1'b1;
                #1;
                fin = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input int i, input logic [1:0] ch,
                                input logic [31:0] t, input logic [31:0] d, input logic e);
        check($sformatf("%s_ch%0d", tag, i), 64'(r_ch[i]), 64'(ch));
        check($sformatf("%s_tempc%0d", tag, i), 64'(r_tempc[i]), 64'(t));
        check($sformatf("%s_drd%0d", tag, i), 64'(r_drd[i]), 64'(d));
        check($sformatf("%s_err%0d", tag, i), 64'(r_err[i]), 64'(e));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tc_base = 32'd0; tc_ref = 8'd0; adc_data = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_tempc", 64'(tempc), 64'd0);
        check("rst_smax", 64'(scan_max), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: all channels 8/16 with base 8
        tc_base = 32'd8; tc_ref = 8'd16; adc_data = {16'd8, 16'd8, 16'd8, 16'd8};
        run_scan(-1, -1, -1, -1);
        check("t1_nres", 64'(n_res), 64'd4);
        check("t1_first_valid", 64'(first_valid), 64'd18);
        check("t1_done_cyc", 64'(done_cyc), 64'd73);
        for (int i = 0; i < 4; i++) check_result("t1", i, 2'(i), 32'd8, 32'd8, 1'b0);
        check("t1_smax", 64'(scan_max), 64'd8);
        check("t1_smax_ch", 64'(scan_max_ch), 64'd0);
        check("t1_busy_at_done", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("t1_busy_after", 64'(busy), 64'd0);
        check("t1_done_pulse", 64'(done), 64'd0);

        // Test 2: mixed samples, base 20, ref 16
        tc_base = 32'd20; tc_ref = 8'd16;
        adc_data = {16'd1000, 16'd65535, 16'd17, 16'd0};
        run_scan(-1, -1, -1, -1);
        check("t2_nres", 64'(n_res), 64'd4);
        check_result("t2", 0, 2'd0, 32'd20, 32'd0, 1'b0);
        check_result("t2", 1, 2'd1, 32'd21, 32'd1, 1'b0);
        check_result("t2", 2, 2'd2, 32'd4115, 32'd15, 1'b0);
        check_result("t2", 3, 2'd3, 32'd82, 32'd8, 1'b0);
        check("t2_smax", 64'(scan_max), 64'd4115);
        check("t2_smax_ch", 64'(scan_max_ch), 64'd2);
        @(posedge clk); #1;
        check("t2_hold_tempc", 64'(tempc), 64'd82);
        check("t2_hold_valid", 64'(res_valid), 64'd0);

        // Test 3: tempc wraps; ties among channels 1..3 keep the lowest
        tc_base = 32'hFFFF_FFF0; tc_ref = 8'd1;
        adc_data = {16'd0, 16'd0, 16'd0, 16'd32};
        run_scan(-1, -1, -1, -1);
        check_result("t3", 0, 2'd0, 32'h0000_0010, 32'd0, 1'b0);
        check_result("t3", 1, 2'd1, 32'hFFFF_FFF0, 32'd0, 1'b0);
        check("t3_smax", 64'(scan_max), 64'hFFFF_FFF0);
        check("t3_smax_ch", 64'(scan_max_ch), 64'd1);

        // Test 4: divide by zero on every channel
        tc_base = 32'd100; tc_ref = 8'd0;
        adc_data = {16'd3, 16'd2, 16'd1, 16'd500};
        run_scan(-1, -1, -1, -1);
        check("t4_first_valid", 64'(first_valid), 64'd2);
        check("t4_done_cyc", 64'(done_cyc), 64'd9);
        check_result("t4", 0, 2'd0, 32'd65635, 32'd500, 1'b1);
        check_result("t4", 1, 2'd1, 32'd65635, 32'd1, 1'b1);
        check("t4_smax", 64'(scan_max), 64'd0);
        check("t4_smax_ch", 64'(scan_max_ch), 64'd0);

        // Test 5: stray starts and input changes mid-scan are ignored
        tc_base = 32'd0; tc_ref = 8'd10;
        adc_data = {16'd99, 16'd7, 16'd123, 16'd45};
        run_scan(5, 40, 10, -1);
        check("t5_nres", 64'(n_res), 64'd4);
        check("t5_done_cyc", 64'(done_cyc), 64'd73);
        check_result("t5", 0, 2'd0, 32'd4, 32'd5, 1'b0);
        check_result("t5", 1, 2'd1, 32'd12, 32'd3, 1'b0);
        check_result("t5", 2, 2'd2, 32'd0, 32'd7, 1'b0);
        check_result("t5", 3, 2'd3, 32'd9, 32'd9, 1'b0);
        check("t5_smax", 64'(scan_max), 64'd12);
        check("t5_smax_ch", 64'(scan_max_ch), 64'd1);

        // Test 5b: start right after done uses the changed inputs
        run_scan(-1, -1, -1, -1);
        check("t5b_done_cyc", 64'(done_cyc), 64'd73);
        check_result("t5b", 0, 2'd0, 32'd22845, 32'd0, 1'b0);
        check("t5b_smax", 64'(scan_max), 64'd22845);

        // Test 6: reset during DIV of channel 2
        tc_base = 32'd7; tc_ref = 8'd5; adc_data = {16'd50, 16'd40, 16'd30, 16'd20};
        run_scan(-1, -1, -1, 40);
        check("t6_nres_before", 64'(n_res), 64'd2);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_valid", 64'(res_valid), 64'd0);
        check("t6_rst_tempc", 64'(tempc), 64'd0);
        check("t6_rst_drd", 64'(drd), 64'd0);
        check("t6_rst_ch", 64'(res_ch), 64'd0);
        check("t6_rst_smax", 64'(scan_max), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_done", 64'(done_cnt) + 64'(done), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        tc_base = 32'd20; tc_ref = 8'd16;
        adc_data = {16'd1000, 16'd65535, 16'd17, 16'd0};
        run_scan(-1, -1, -1, -1);
        check("t6_nres", 64'(n_res), 64'd4);
        check("t6_done_cyc", 64'(done_cyc), 64'd73);
        check_result("t6", 0, 2'd0, 32'd20, 32'd0, 1'b0);
        check_result("t6", 2, 2'd2, 32'd4115, 32'd15, 1'b0);
        check("t6_smax", 64'(scan_max), 64'd4115);
        check("t6_smax_ch", 64'(scan_max_ch), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/temperature_scanner.md
# temperature_scanner

Parametrised, multi-channel sequential successor to the combinational temperature calculator. On a start pulse it snapshots one shared base/reference pair and CHANNELS ADC samples. It then computes, channel by channel with an iterative restoring divider, tempc = tc_base + adc/tc_ref and drd = adc % tc_ref. Each result is streamed out with a valid strobe, and a per-scan maximum is tracked for the house-climate controller.

## Interface
- CHANNELS, 4, number of ADC channels per scan (>= 1)
- ADC_W, 16, ADC sample width (dividend)
- REF_W, 8, reference width (divisor), REF_W <= ADC_W
- OUT_W, 32, width of tc_base, tempc, drd, scan_max, ADC_W <= OUT_W
- CH_W, max(1, $clog2(CHANNELS)), channel-index width (derived)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  scan request, sampled only in IDLE
- tc_base  in  OUT_W  base temperature offset
- tc_ref  in  REF_W  divisor, shared by all channels
- adc_data  in  ADC_W*CHANNELS  packed samples, channel i = bits [i*ADC_W +: ADC_W]
- busy  out  1  high from the cycle after start is accepted until done
- res_valid  out  1  one-cycle strobe, result fields valid
- res_ch  out  CH_W  channel of current result
- tempc  out  OUT_W  tc_base + quotient
- drd  out  OUT_W  remainder, zero-extended
- div_err  out  1  tc_ref was zero for this result
- done  out  1  one-cycle end-of-scan pulse
- scan_max  out  OUT_W  largest valid tempc of last completed scan
- scan_max_ch  out  CH_W  channel of scan_max

## Operation
- States: IDLE, LOAD, DIV, EMIT, DONE.
- IDLE: when start=1, register tc_base, tc_ref and all of adc_data, set ch=0 and go to LOAD. A start outside IDLE is ignored, and the snapshot is immune to later input changes.
- LOAD: set dividend = adc[ch], rem=0, bit counter=ADC_W-1.
  - If tc_ref==0, go directly to EMIT with quotient = all ones (ADC_W bits), drd = adc[ch], div_err=1.
  - Otherwise go to DIV.
- DIV: one restoring step per cycle for ADC_W cycles. Shift {rem,dividend} left, subtract tc_ref when rem >= tc_ref, and set the quotient bit. After the last step go to EMIT.
- EMIT: drive res_valid=1 with res_ch=ch, tempc = tc_base + zero-extended quotient (mod 2^OUT_W, wraps silently), drd = zero-extended remainder, and div_err.
  - Update the running max when div_err=0 and tempc > running max (strict unsigned compare, so ties keep the lower channel).
  - If ch==CHANNELS-1 go to DONE, else increment ch and go to LOAD.
- DONE: done=1 for one cycle, commit the running max to scan_max/scan_max_ch, clear the running max to 0/0, go to IDLE.
- If every channel errs, scan_max=0 and scan_max_ch=0.
- tempc/drd/res_ch/div_err hold their last EMIT values between strobes.

## Timing
- Reset values: busy=0, res_valid=0, done=0, res_ch=0, tempc=0, drd=0, div_err=0, scan_max=0, scan_max_ch=0, state=IDLE.
- Per channel with tc_ref != 0: 1 LOAD + ADC_W DIV + 1 EMIT = ADC_W+2 cycles. With tc_ref = 0: 2 cycles.
- The first res_valid comes ADC_W+2 cycles after the start edge. done follows the last EMIT by 1 cycle.
- A full scan (start edge to done) takes CHANNELS*(ADC_W+2)+1 cycles. With defaults that is 73.
- busy=1 in LOAD, DIV, EMIT and DONE; busy=0 in IDLE.
- The earliest next start accepted is the cycle after done, when the block is back in IDLE.
- Reset asserted mid-scan aborts immediately to reset values. There is no partial done, and scan_max is cleared.

## Test plan
- Defaults, tc_base=8, tc_ref=16, all adc=8 -> four strobes, res_ch 0..3, tempc=8, drd=8, div_err=0; done at cycle 73; scan_max=8, scan_max_ch=0.
- tc_base=20, tc_ref=16, adc={ch3=1000, ch2=65535, ch1=17, ch0=0} -> ch0 tempc=20 drd=0; ch1 21/1; ch2 4115/15; ch3 82/8; scan_max=4115, scan_max_ch=2.
- tc_base=32'hFFFF_FFF0, tc_ref=1, adc ch0=32 -> ch0 tempc=32'h0000_0010 (wrap), drd=0.
- tc_ref=0, adc ch0=500 -> div_err=1, tempc=tc_base+65535, drd=500; each channel takes 2 cycles; scan_max=0, scan_max_ch=0.
- Pulse start again at cycles 5 and 40 of a scan, and change adc_data mid-scan -> ignored, results match the snapshot. A start the cycle after done begins a new scan.
- Assert rst during DIV of ch2 -> all outputs return to 0 asynchronously, and done never pulses. A fresh start after release gives correct results from ch0.
